// File: rtl/idli_uart_rx_m.sv
// idli_uart_rx_m -- 8N1 UART receiver with a one-byte, nibble-wide output buffer.
//
// The serial line is synchronized into the core clock domain. Each bit is
// sampled near its centre by a bit-cycle counter. A completed byte with a
// valid stop bit goes into a one-byte buffer. The buffer is read out as two
// 4-bit nibbles, low nibble first, through a valid/accept handshake.
//
// Ports
//   i_urx_gck        in   core clock; all state changes on its rising edge
//   i_urx_rst_n      in   asynchronous active-low reset
//   i_urx_rx         in   serial line (idle high, 8N1, LSB first), asynchronous
//   o_urx_data       out  buffered nibble; reads 0 while o_urx_data_vld is low
//   o_urx_data_vld   out  o_urx_data holds a valid nibble
//   i_urx_data_acp   in   consumer takes o_urx_data this cycle
//   o_urx_frame_err  out  one-cycle pulse: stop bit sampled low, byte dropped
//   o_urx_overrun    out  one-cycle pulse: good byte dropped, buffer was full

package idli_uart_rx_pkg;
    typedef logic [3:0] sqi_data_t;
endpackage

module idli_uart_rx_m
    import idli_uart_rx_pkg::*;
#(
    parameter int BIT_CYCLES = 16  // clock cycles per bit; even and >= 4
) (
    input  logic      i_urx_gck,
    input  logic      i_urx_rst_n,
    input  logic      i_urx_rx,
    output sqi_data_t o_urx_data,
    output logic      o_urx_data_vld,
    input  logic      i_urx_data_acp,
    output logic      o_urx_frame_err,
    output logic      o_urx_overrun
);

    localparam int              CW        = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0]   HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    // Line synchronizer
    logic rx_meta, rx_sync;

    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make rx_sync take the previous
            // rx_meta, so the two flops form a real two-stage chain.
            rx_meta <= i_urx_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_ok, stop_bad;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_sync) state_d = START;
            end
            START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                // The counter was aligned to mid-start, so a full bit period
                // later lands in the middle of each data bit.
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    stop_ok  = rx_sync;
                    stop_bad = !rx_sync;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output buffer: one byte, presented low nibble then high nibble
    logic [7:0] buf_q, buf_d;
    logic       occ_q, occ_d;   // buffer holds a byte
    logic       hi_q, hi_d;     // presenting byte[7:4]
    logic       acp_take, buf_free, overrun_d;

    assign acp_take  = occ_q && i_urx_data_acp;
    // Accepting the high nibble frees the buffer in the same cycle, so a byte
    // completing on that edge loads straight in without a valid gap.
    assign buf_free  = !occ_q || (hi_q && i_urx_data_acp);
    assign overrun_d = stop_ok && !buf_free;

    always_comb begin
        occ_d = occ_q;
        hi_d  = hi_q;
        buf_d = buf_q;
        if (acp_take) begin
            if (hi_q) occ_d = 1'b0;
            else      hi_d  = 1'b1;
        end
        if (stop_ok && buf_free) begin
            buf_d = shift_q;
            occ_d = 1'b1;
            hi_d  = 1'b0;
        end
    end

    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            occ_q           <= 1'b0;
            hi_q            <= 1'b0;
            o_urx_frame_err <= 1'b0;
            o_urx_overrun   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            occ_q           <= occ_d;
            hi_q            <= hi_d;
            o_urx_frame_err <= stop_bad;
            o_urx_overrun   <= overrun_d;
        end
    end

    // NOTE: the data registers have no reset. Their contents are only seen
    // while occ_q is set, and every path that sets occ_q also loads them.
    always_ff @(posedge i_urx_gck) begin
        shift_q <= shift_d;
        buf_q   <= buf_d;
    end

    assign o_urx_data_vld = occ_q;
    assign o_urx_data     = !occ_q ? '0 : (hi_q ? buf_q[7:4] : buf_q[3:0]);

endmodule

// File: tb/tb_idli_uart_rx_m.sv
module tb_idli_uart_rx_m;

    localparam int BC = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [3:0] data;
    logic       vld;
    logic       acp;
    logic       frame_err;
    logic       overrun;

    idli_uart_rx_m #(.BIT_CYCLES(BC)) dut (
        .i_urx_gck       (clk),
        .i_urx_rst_n     (rst_n),
        .i_urx_rx        (rx),
        .o_urx_data      (data),
        .o_urx_data_vld  (vld),
        .i_urx_data_acp  (acp),
        .o_urx_frame_err (frame_err),
        .o_urx_overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] got_q[$];   // nibbles the consumer accepted
    logic [3:0] exp_q[$];   // nibbles the model predicts
    int         fe_cnt = 0, ov_cnt = 0, vld_hi_cnt = 0, vld_lo_cnt = 0, viol = 0;
    logic       abort_tx = 1'b0;
    logic       rand_on  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a good byte is delivered as low nibble then high nibble.
    task automatic model_push(input logic [7:0] b);
        exp_q.push_back(b[3:0]);
        exp_q.push_back(b[7:4]);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_nib%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Drives one 8N1 frame, one bit per BC clocks; stops early on abort_tx.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < BC; c++) begin
                if (abort_tx) begin
                    rx = 1'b1;
                    return;
                end
                tick();
            end
        end
        rx = 1'b1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic       prev_hold;
        logic       prev_vld;
        logic [3:0] prev_data;
        prev_hold = 1'b0;
        prev_vld  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (!vld && data != 4'h0) viol++;
                if (prev_hold && (vld !== prev_vld || data !== prev_data)) viol++;
                if (vld && acp) got_q.push_back(data);
                if (frame_err) fe_cnt++;
                if (overrun)   ov_cnt++;
                if (vld) vld_hi_cnt++;
                else     vld_lo_cnt++;
                prev_hold = vld && !acp;
                prev_vld  = vld;
                prev_data = data;
            end
        end
    end

    initial begin
        int         lat;
        int         fe0, ov0, hi0, lo0, n_bad;
        logic [7:0] b;
        logic       st;

        rst_n = 1'b0;
        rx    = 1'b1;
        acp   = 1'b0;
        #1;
        check("rst_data", data, 4'h0);
        check("rst_vld", vld, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_ov", overrun, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // 0xA5 with the consumer always ready; check first-valid latency.
        acp = 1'b1;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 200; n++) begin
                    tick();
                    if (vld) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        model_push(8'hA5);
        repeat (5) tick();
        if (lat < 153 || lat > 155)
            $display("note: a5 first-valid latency %0d cycles", lat);
        check("a5_latency_in_window", (lat >= 153 && lat <= 155), 1'b1);
        compare_stream("a5");
        check("a5_no_fe", fe_cnt - fe0, 0);
        check("a5_no_ov", ov_cnt - ov0, 0);

        // Short low glitch: false start, nothing reported.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        hi0 = vld_hi_cnt;
        rx  = 1'b0;
        repeat (4) tick();
        rx  = 1'b1;
        repeat (40) tick();
        check("glitch_no_vld", vld_hi_cnt - hi0, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        check("glitch_no_ov", ov_cnt - ov0, 0);

        // Bad stop bit, then a good frame.
        fe0 = fe_cnt;
        hi0 = vld_hi_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (20) tick();
        check("fe_pulse_cycles", fe_cnt - fe0, 1);
        check("fe_no_vld", vld_hi_cnt - hi0, 0);
        send_frame(8'h81, 1'b1);
        model_push(8'h81);
        repeat (5) tick();
        compare_stream("after_fe");

        // Consumer stalls across two frames: second byte overruns.
        acp = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1);
        repeat (3) tick();
        check("stall_vld", vld, 1'b1);
        check("stall_data", data, 4'h2);
        send_frame(8'h34, 1'b1);
        repeat (3) tick();
        check("overrun_once", ov_cnt - ov0, 1);
        check("overrun_kept_data", data, 4'h2);
        model_push(8'h12);
        acp = 1'b1;
        repeat (3) tick();
        acp = 1'b0;
        check("overrun_drained", vld, 1'b0);
        compare_stream("overrun");

        // High nibble accepted on the stop-sample edge of the next frame.
        // Stop sample lands 2 (sync) + 1 (detect) + 8 + 128 + 16 = 155 edges
        // after the start bit is driven.
        ov0 = ov_cnt;
        send_frame(8'h56, 1'b1);
        model_push(8'h56);
        repeat (3) tick();
        check("hand_lo", data, 4'h6);
        acp = 1'b1;
        tick();
        acp = 1'b0;
        check("hand_hi", data, 4'h5);
        lo0 = vld_lo_cnt;
        fork
            send_frame(8'h78, 1'b1);
            begin
                repeat (154) tick();
                acp = 1'b1;
                tick();
                acp = 1'b0;
            end
        join
        model_push(8'h78);
        check("hand_next_lo", data, 4'h8);
        acp = 1'b1;
        repeat (2) tick();
        check("hand_no_gap", vld_lo_cnt - lo0, 0);
        acp = 1'b0;
        tick();
        check("hand_no_ov", ov_cnt - ov0, 0);
        compare_stream("handoff");

        // Reset mid-frame with a byte still buffered.
        send_frame(8'hC3, 1'b1);
        repeat (2) tick();
        check("pre_reset_vld", vld, 1'b1);
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                repeat (60) tick();
                #2;
                rst_n    = 1'b0;
                abort_tx = 1'b1;
            end
        join
        #1;
        check("midrst_vld", vld, 1'b0);
        check("midrst_data", data, 4'h0);
        check("midrst_fe", frame_err, 1'b0);
        check("midrst_ov", overrun, 1'b0);
        repeat (3) tick();
        rst_n    = 1'b1;
        abort_tx = 1'b0;
        got_q.delete();
        exp_q.delete();
        hi0 = vld_hi_cnt;
        repeat (30) tick();
        check("midrst_no_output", vld_hi_cnt - hi0, 0);
        acp = 1'b1;
        send_frame(8'h9E, 1'b1);
        model_push(8'h9E);
        repeat (5) tick();
        compare_stream("after_reset");

        // Random frames, random stop errors, randomly stalling consumer.
        fe0     = fe_cnt;
        ov0     = ov_cnt;
        n_bad   = 0;
        rand_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 12; f++) begin
                    b  = 8'($urandom);
                    st = ($urandom_range(0, 5) != 0);
                    send_frame(b, st);
                    if (st) model_push(b);
                    else    n_bad++;
                    repeat ($urandom_range(20, 40)) tick();
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    acp = 1'($urandom_range(0, 1));
                    tick();
                end
                acp = 1'b1;
            end
        join
        repeat (10) tick();
        compare_stream("random");
        check("random_fe_count", fe_cnt - fe0, n_bad);
        check("random_no_ov", ov_cnt - ov0, 0);

        check("protocol_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/idli_uart_rx_m.md
IDLI_UART_RX_M -- requirements
Module: idli_uart_rx_m

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 16, clock cycles per UART bit; legal values are even and >= 4.
REQ-002 SHALL have port i_urx_gck  input  1  core clock; all state is on its rising edge.
REQ-003 SHALL have port i_urx_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_urx_rx  input  1  serial line, asynchronous to i_urx_gck, idle high, 8N1, LSB first.
REQ-005 SHALL have port o_urx_data  output  sqi_data_t (4)  received nibble presented to the consumer.
REQ-006 SHALL have port o_urx_data_vld  output  1  o_urx_data is valid.
REQ-007 SHALL have port i_urx_data_acp  input  1  consumer accepts o_urx_data this cycle.
REQ-008 SHALL have port o_urx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port o_urx_overrun  output  1  one-cycle pulse; complete byte dropped because the buffer was full.

Function
REQ-010 SHALL pass i_urx_rx through a 2-flop synchronizer; both flops reset to 1; all sampling uses the synchronized value.
REQ-011 SHALL implement a receive FSM with states IDLE, START, DATA, STOP and a bit-cycle counter of width clog2(BIT_CYCLES).
REQ-012 IDLE: synchronized line low SHALL move the FSM to START and clear the counter.
REQ-013 START: when the counter reaches BIT_CYCLES/2-1, the line SHALL be sampled; low -> DATA, counter cleared, bit index 0; high -> false start, return to IDLE with no output or error.
REQ-014 DATA: each time the counter reaches BIT_CYCLES-1, the line SHALL be sampled into shift-register bit [index], the counter cleared, and the index incremented; after index 7 the FSM SHALL move to STOP.
REQ-015 STOP: when the counter reaches BIT_CYCLES-1, the line SHALL be sampled and the FSM SHALL return to IDLE in the same edge.
REQ-016 A stop sample of 1 SHALL commit the byte to the output buffer if the buffer is free; otherwise o_urx_overrun SHALL pulse for 1 cycle, the new byte SHALL be dropped, and the buffered byte SHALL be kept intact.
REQ-017 A stop sample of 0 SHALL pulse o_urx_frame_err for 1 cycle and drop the byte; IDLE then restarts detection only on the line being low, so a held-low break produces a new START.
REQ-018 The output buffer SHALL hold one byte in two phases: phase LO presents byte[3:0], phase HI presents byte[7:4].
REQ-019 o_urx_data_vld SHALL be high whenever the buffer is occupied, starting the cycle after the committing edge.
REQ-020 i_urx_data_acp while vld is high SHALL advance LO->HI, or HI->empty; acp while vld is low SHALL be ignored.
REQ-021 o_urx_data_vld and o_urx_data SHALL NOT change while vld is high and acp is low.
REQ-022 The buffer SHALL count as free for a commit in the same cycle that the HI nibble is accepted; the new byte loads in phase LO with no overrun and no vld gap.
REQ-023 o_urx_data SHALL read 0 while vld is low.
REQ-024 Receive and output buffering SHALL be independent; a frame SHALL be received while the consumer stalls.

Reset
REQ-025 Asserting i_urx_rst_n low at any time, including mid-frame, SHALL asynchronously force: FSM IDLE; counter and index 0; synchronizer flops 1; buffer empty.
REQ-026 Under reset, outputs SHALL read o_urx_data=0, o_urx_data_vld=0, o_urx_frame_err=0, o_urx_overrun=0.
REQ-027 A partially received frame at reset SHALL be discarded, and reception after deassertion SHALL resume only at the next falling edge.

Verification (BIT_CYCLES=16)
REQ-028 Send 0xA5 with acp held high -> vld for 2 cycles, data 0x5 then 0xA; the first vld occurs 2+8+128+16 cycles after the start-bit edge (+-1); no error pulses.
REQ-029 Send a 4-cycle low glitch -> FSM returns to IDLE; vld, frame_err, and overrun stay 0.
REQ-030 Send 0x3C with the stop bit driven 0 -> frame_err pulses exactly 1 cycle; vld stays 0; a following 0x81 frame is received correctly (0x1, 0x8).
REQ-031 Send 0x12 then 0x34 with acp low -> vld holds with data 0x2; overrun pulses once at the stop of 0x34; after acp, the data read is 0x2, 0x1, then empty.
REQ-032 Send 0x56 and hold it, then accept the HI nibble on the exact stop-sample cycle of 0x78 -> no overrun; vld stays high continuously; the data sequence is 0x6, 0x5, 0x8, 0x7.
REQ-033 Assert reset mid-DATA of a frame, then send 0x9E -> no output from the aborted frame; 0xE then 0x9 are delivered.
